// File: rtl/pes_cc_arbiter.sv
// pes_cc_arbiter: round-robin fill/writeback front end and one-at-a-time sequencer
// for the shared 256-bit cache-line compressor, with saturating statistics.
module pes_cc_arbiter #(
  parameter int CC_LAT = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [255:0]     in0_line,
  input  logic [TAG_W-1:0] in0_tag,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [255:0]     in1_line,
  input  logic [TAG_W-1:0] in1_tag,
  output logic [255:0]     cc_line,
  output logic             cc_start,
  input  logic [255:0]     cc_result,
  input  logic [2:0]       cc_fmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_line,
  output logic [2:0]       out_fmt,
  output logic [8:0]       out_bits,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      cnt_ops,
  output logic [23:0]      cnt_saved
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, src_q, src_d, g1;
  logic [3:0] wait_q, wait_d;
  logic [255:0] line_q, line_d, res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0] fmt_q, fmt_d;
  logic [8:0] bits_q, bits_d, dec_bits;
  logic [15:0] cnt_ops_q, cnt_ops_d;
  logic [23:0] cnt_saved_q, cnt_saved_d;
  logic [24:0] sum;
  // port 1 wins when it is alone or when both ask and the pointer favours it
  assign g1 = in1_valid & (~in0_valid | rr_q);
  assign in0_ready = reset_n & (state_q == IDLE) & in0_valid & ~g1;
  assign in1_ready = reset_n & (state_q == IDLE) & g1;
  assign cc_start = state_q == START;
  assign cc_line = line_q;
  assign out_valid = state_q == RESP;
  assign out_line = res_q;
  assign out_fmt = fmt_q;
  assign out_bits = bits_q;
  assign out_src = src_q;
  assign out_tag = tag_q;
  assign cnt_ops = cnt_ops_q;
  assign cnt_saved = cnt_saved_q;
  assign sum = {1'b0, cnt_saved_q} + {16'd0, 9'h100 - bits_q};
  always_comb begin
    case (cc_fmt)
      3'd1, 3'd4: dec_bits = 9'd96;
      3'd2:       dec_bits = 9'd128;
      3'd3:       dec_bits = 9'd192;
      3'd5:       dec_bits = 9'd160;
      3'd6:       dec_bits = 9'd144;
      default:    dec_bits = 9'h100;
    endcase
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    src_d = src_q;
    wait_d = wait_q;
    line_d = line_q;
    tag_d = tag_q;
    res_d = res_q;
    fmt_d = fmt_q;
    bits_d = bits_q;
    cnt_ops_d = cnt_ops_q;
    cnt_saved_d = cnt_saved_q;
    case (state_q)
      IDLE: if (in0_valid | in1_valid) begin
        state_d = START;
        line_d = g1 ? in1_line : in0_line;
        tag_d = g1 ? in1_tag : in0_tag;
        src_d = g1;
        rr_d = ~g1;
      end
      START: begin
        wait_d = 4'(CC_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (wait_q == 4'd0) begin
        res_d = cc_result;
        fmt_d = cc_fmt;
        bits_d = dec_bits;
        state_d = RESP;
      end else wait_d = wait_q - 4'd1;
      default: if (out_ready) begin
        state_d = IDLE;
        cnt_ops_d = &cnt_ops_q ? cnt_ops_q : cnt_ops_q + 16'd1;
        cnt_saved_d = sum[24] ? 24'hFFFFFF : sum[23:0];
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      src_q <= 1'b0;
      wait_q <= '0;
      line_q <= '0;
      tag_q <= '0;
      res_q <= '0;
      fmt_q <= '0;
      bits_q <= '0;
      cnt_ops_q <= '0;
      cnt_saved_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      src_q <= src_d;
      wait_q <= wait_d;
      line_q <= line_d;
      tag_q <= tag_d;
      res_q <= res_d;
      fmt_q <= fmt_d;
      bits_q <= bits_d;
      cnt_ops_q <= cnt_ops_d;
      cnt_saved_q <= cnt_saved_d;
    end
  end
endmodule
